data_memory_controller: RTL and testbench
=========================================

Name: data_memory_controller

Overview:
- Responder side of the data-memory interface driven by the pipeline memory stage (read, write, memory_addr, data_to_write in; read_data_from_memory_controller out).
- Holds a word-organised data RAM and serves one load or store at a time with a parameterised number of wait cycles.
- Handles RV32I byte, halfword and word accesses, including lane merge and sign/zero extension.
- Reports busy, done and misalignment so the pipeline can stall and flag errors.

Parameters:
DEPTH, 1024, number of 32-bit words in the RAM; must be a power of two; ADDR_BITS = log2(DEPTH).
WAIT_CYCLES, 2, extra cycles between acceptance and completion; 0 is legal.

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
read  input  1  load request
write  input  1  store request
memory_addr  input  32  byte address
data_to_write  input  32  store data, right-aligned (byte in [7:0], half in [15:0])
access_size  input  2  00 byte, 01 half, 10 word, 11 treated as word
load_unsigned  input  1  1 = zero-extend loads (lbu/lhu), 0 = sign-extend
read_data_from_memory_controller  output  32  load result
mem_busy  output  1  request in progress; pipeline stalls while high
mem_done  output  1  one-cycle completion pulse
misaligned_error  output  1  one-cycle pulse with mem_done on a misaligned access

Behaviour:
- Interface: one clock (clk), synchronous active-high reset (rst).
- FSM states:
  - IDLE. If read XOR write is high at the clock edge, latch addr, data, size, unsigned and direction. Go to WAIT if WAIT_CYCLES>0, else go to DONE.
  - WAIT. A down-counter loads WAIT_CYCLES-1 on acceptance. Go to DONE when it reaches 0.
  - DONE. Lasts one cycle, then returns to IDLE.
- Latency: request accepted at edge N; mem_done is high during cycle N+1+WAIT_CYCLES.
- Request rules:
  - read and write both high in IDLE: ignored, no state change.
  - Requests are sampled only in IDLE. Request lines present during WAIT or DONE are ignored. A request still held in the cycle after DONE is accepted again as a new access; the pipeline must deassert or advance.
- mem_busy: high in WAIT and DONE, low in IDLE (registered). mem_done: high only in DONE.
- Word index = addr[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Misaligned access: half with addr[0]=1, or word with addr[1:0]!=00.
  - misaligned_error and mem_done pulse together in DONE.
  - No RAM write. read_data_from_memory_controller is set to 0.
- Store: commits in the DONE cycle using byte lanes from latched addr[1:0].
  - Byte writes lane addr[1:0]. Half writes lanes {addr[1],0} and {addr[1],1}. Word writes all four lanes.
  - Other lanes are unchanged.
- Load: in DONE, select the byte/half by latched addr[1:0], extend per load_unsigned, and register it into read_data_from_memory_controller.
  - Value is valid from the cycle after DONE and holds until the next completed load.
  - A word load ignores load_unsigned.
- Stores never change read_data_from_memory_controller.
- Reset: state=IDLE, counter=0, mem_busy=0, mem_done=0, misaligned_error=0, read_data_from_memory_controller=0.
  - Reset mid-WAIT or mid-DONE aborts the access; a pending store is not committed.
  - RAM contents are not cleared by reset.

Test Plan:
- WAIT_CYCLES=2: sw 0x11223344 to 0x100 at edge 0 -> mem_busy high cycles 1-3, mem_done high cycle 3 only. Then lw 0x100 -> read_data_from_memory_controller=0x11223344 after its DONE.
- After word 0x11223344 at 0x100: sb 0xAB to 0x101 -> word 0x1122AB44. Then lb 0x101 -> 0xFFFFFFAB; lbu 0x101 -> 0x000000AB; lhu 0x102 -> 0x00001122; lh 0x100 -> 0xFFFFAB44.
- lh at 0x103 and sw at 0x102 -> misaligned_error and mem_done pulse together; RAM unchanged; load result 0.
- read=write=1 in IDLE -> no acceptance, mem_busy stays 0. Then with DEPTH=1024, sw 0xDEADBEEF to 0x1000 -> lw 0x0 returns 0xDEADBEEF (wrap).
- sw 0xCAFEF00D to 0x200 with rst asserted during WAIT -> outputs reset next cycle; lw 0x200 still returns the prior contents.
- WAIT_CYCLES=0: back-to-back lw requests held one cycle each, with an idle gap -> each mem_done arrives 1 cycle after acceptance; requests during DONE are ignored.

Source files
------------

// File: rtl/data_memory_controller_if.sv
// Data-memory request/response bundle between the pipeline memory stage and the memory controller.
interface data_memory_controller_if;
  logic        read;
  logic        write;
  logic [31:0] memory_addr;
  logic [31:0] data_to_write;
  logic [1:0]  access_size;
  logic        load_unsigned;
  logic [31:0] read_data_from_memory_controller;
  logic        mem_busy;
  logic        mem_done;
  logic        misaligned_error;

  modport master (
    output read, write, memory_addr, data_to_write, access_size, load_unsigned,
    input  read_data_from_memory_controller, mem_busy, mem_done, misaligned_error
  );

  modport slave (
    input  read, write, memory_addr, data_to_write, access_size, load_unsigned,
    output read_data_from_memory_controller, mem_busy, mem_done, misaligned_error
  );
endinterface

// File: rtl/data_memory_controller.sv
// Word-organised data RAM serving one RV32I load/store at a time with a fixed wait latency.
// state  | meaning
// IDLE   | waiting for exactly one of read/write
// WAIT   | access latched, counting down extra wait cycles
// DONE   | one-cycle completion: store commits, load result registers
module data_memory_controller #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic rst,
  data_memory_controller_if.slave bus
);
  localparam int ADDR_BITS = $clog2(DEPTH);
  localparam int CW        = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_INIT = (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [ADDR_BITS+1:0]   addr_q;
  logic [31:0]            data_q;
  logic [1:0]             size_q;
  logic                   uns_q;
  logic                   wr_q;
  logic                   mis_q;

  logic                   busy_r;
  logic                   done_r;
  logic                   mis_r;
  logic [31:0]            rdata_r;

  logic [31:0]            mem [DEPTH];

  logic                   req_ok;
  logic                   mis_in;
  logic [1:0]             lane;
  logic [ADDR_BITS-1:0]   word_idx;
  logic [31:0]            word_rd;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [31:0]            load_val;
  logic [3:0]             wr_be;
  logic [31:0]            wr_data;
  logic                   mem_we;
  logic                   unused_addr_hi;

  assign unused_addr_hi = ^bus.memory_addr[31:ADDR_BITS+2];

  assign req_ok   = bus.read ^ bus.write;
  assign lane     = addr_q[1:0];
  assign word_idx = addr_q[ADDR_BITS+1:2];
  assign word_rd  = mem[word_idx];

  always_comb begin
    mis_in = 1'b0;
    case (bus.access_size)
      2'b00:   mis_in = 1'b0;
      2'b01:   mis_in = bus.memory_addr[0];
      default: mis_in = |bus.memory_addr[1:0];
    endcase
  end

  always_comb begin
    byte_sel = word_rd[{lane, 3'b000} +: 8];
    half_sel = addr_q[1] ? word_rd[31:16] : word_rd[15:0];
    load_val = word_rd;
    case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      2'b01:   load_val = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      default: load_val = word_rd;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target.
  always_comb begin
    wr_be   = 4'b1111;
    wr_data = data_q;
    case (size_q)
      2'b00: begin
        wr_be   = 4'b0001 << lane;
        wr_data = {4{data_q[7:0]}};
      end
      2'b01: begin
        wr_be   = addr_q[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{data_q[15:0]}};
      end
      default: begin
        wr_be   = 4'b1111;
        wr_data = data_q;
      end
    endcase
  end

  // A reset landing on the DONE edge suppresses the commit.
  assign mem_we = (state == S_DONE) && wr_q && !mis_q && !rst;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      mis_r   <= 1'b0;
      rdata_r <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wr_q    <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_ok) begin
            addr_q <= bus.memory_addr[ADDR_BITS+1:0];
            data_q <= bus.data_to_write;
            size_q <= bus.access_size;
            uns_q  <= bus.load_unsigned;
            wr_q   <= bus.write;
            mis_q  <= mis_in;
            busy_r <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state  <= S_DONE;
              done_r <= 1'b1;
              mis_r  <= mis_in;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == '0) begin
            state  <= S_DONE;
            done_r <= 1'b1;
            mis_r  <= mis_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
          mis_r  <= 1'b0;
          if (!wr_q) rdata_r <= mis_q ? 32'h0 : load_val;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_busy                         = busy_r;
  assign bus.mem_done                         = done_r;
  assign bus.misaligned_error                 = mis_r;
  assign bus.read_data_from_memory_controller = rdata_r;
endmodule

// File: tb/tb_data_memory_controller.sv
// Self-checking bench: directed table, hand-written corner sequences and random traffic vs a byte-array model.
module tb_data_memory_controller;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  data_memory_controller_if a_if ();
  data_memory_controller_if b_if ();

  data_memory_controller #(.DEPTH(1024), .WAIT_CYCLES(2)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  data_memory_controller #(.DEPTH(1024), .WAIT_CYCLES(0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  // Reference model of dut_a: byte-addressed image of its RAM and its last load result.
  logic [7:0]  mdl [4096];
  logic [31:0] mdl_rd;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sz;
    bit          uns;
    bit          mis;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [19];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] ad);
    if (sz == 2'd0) return 1'b0;
    if (sz == 2'd1) return ad[0];
    return (ad % 4) != 0;
  endfunction

  task automatic model_apply(input bit wr, input logic [31:0] ad, input logic [31:0] d,
                             input logic [1:0] sz, input bit uns);
    int a;
    int n;
    logic [31:0] v;
    a = int'(ad % 4096);
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (model_mis(sz, ad)) begin
      if (!wr) mdl_rd = 32'h0;
      return;
    end
    if (wr) begin
      for (int i = 0; i < n; i++) mdl[a + i] = d[8*i +: 8];
    end else begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v = v | (32'(mdl[a + i]) << (8 * i));
      if (!uns && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!uns && n == 2 && v[15]) v = v | 32'hFFFF_0000;
      mdl_rd = v;
    end
  endtask

  task automatic acc_a(input bit wr, input logic [31:0] ad, input logic [31:0] d,
                       input logic [1:0] sz, input bit uns,
                       output logic [31:0] got_rd, output logic got_mis);
    int cyc;
    @(negedge clk);
    a_if.read          = !wr;
    a_if.write         = wr;
    a_if.memory_addr   = ad;
    a_if.data_to_write = d;
    a_if.access_size   = sz;
    a_if.load_unsigned = uns;
    @(negedge clk);
    a_if.read  = 1'b0;
    a_if.write = 1'b0;
    check("busy_after_accept", 32'(a_if.mem_busy), 32'd1);
    cyc = 1;
    while (!a_if.mem_done && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("done_latency", 32'(cyc), 32'd3);
    check("busy_in_done", 32'(a_if.mem_busy), 32'd1);
    got_mis = a_if.misaligned_error;
    @(negedge clk);
    check("busy_clear", 32'(a_if.mem_busy), 32'd0);
    check("done_clear", 32'(a_if.mem_done), 32'd0);
    check("mis_clear", 32'(a_if.misaligned_error), 32'd0);
    got_rd = a_if.read_data_from_memory_controller;
    model_apply(wr, ad, d, sz, uns);
  endtask

  task automatic b_store(input logic [31:0] ad, input logic [31:0] d);
    @(negedge clk);
    b_if.write         = 1'b1;
    b_if.memory_addr   = ad;
    b_if.data_to_write = d;
    b_if.access_size   = 2'd2;
    @(negedge clk);
    b_if.write = 1'b0;
    check("b_store_done", 32'(b_if.mem_done), 32'd1);
    @(negedge clk);
    check("b_store_idle", 32'(b_if.mem_busy), 32'd0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        mis;
    bit          wr;
    logic [31:0] ad;
    logic [31:0] d;
    logic [1:0]  sz;
    bit          uns;

    tbl[0]  = '{1'b1, 32'h100,  32'h1122_3344, 2'd2, 1'b0, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 32'h100,  32'h0,         2'd2, 1'b0, 1'b0, 32'h1122_3344};
    tbl[2]  = '{1'b1, 32'h101,  32'h1234_56AB, 2'd0, 1'b0, 1'b0, 32'h1122_3344};
    tbl[3]  = '{1'b0, 32'h100,  32'h0,         2'd2, 1'b0, 1'b0, 32'h1122_AB44};
    tbl[4]  = '{1'b0, 32'h101,  32'h0,         2'd0, 1'b0, 1'b0, 32'hFFFF_FFAB};
    tbl[5]  = '{1'b0, 32'h101,  32'h0,         2'd0, 1'b1, 1'b0, 32'h0000_00AB};
    tbl[6]  = '{1'b0, 32'h102,  32'h0,         2'd1, 1'b1, 1'b0, 32'h0000_1122};
    tbl[7]  = '{1'b0, 32'h100,  32'h0,         2'd1, 1'b0, 1'b0, 32'hFFFF_AB44};
    tbl[8]  = '{1'b0, 32'h103,  32'h0,         2'd1, 1'b0, 1'b1, 32'h0000_0000};
    tbl[9]  = '{1'b1, 32'h102,  32'h5555_5555, 2'd2, 1'b0, 1'b1, 32'h0000_0000};
    tbl[10] = '{1'b0, 32'h100,  32'h0,         2'd3, 1'b1, 1'b0, 32'h1122_AB44};
    tbl[11] = '{1'b1, 32'h1000, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, 32'h1122_AB44};
    tbl[12] = '{1'b0, 32'h0,    32'h0,         2'd2, 1'b0, 1'b0, 32'hDEAD_BEEF};
    tbl[13] = '{1'b1, 32'h104,  32'h0000_0000, 2'd2, 1'b0, 1'b0, 32'hDEAD_BEEF};
    tbl[14] = '{1'b1, 32'h106,  32'hABCD_8001, 2'd1, 1'b0, 1'b0, 32'hDEAD_BEEF};
    tbl[15] = '{1'b0, 32'h104,  32'h0,         2'd2, 1'b0, 1'b0, 32'h8001_0000};
    tbl[16] = '{1'b0, 32'h106,  32'h0,         2'd1, 1'b0, 1'b0, 32'hFFFF_8001};
    tbl[17] = '{1'b0, 32'h107,  32'h0,         2'd0, 1'b0, 1'b0, 32'hFFFF_FF80};
    tbl[18] = '{1'b0, 32'h101,  32'h0,         2'd2, 1'b0, 1'b1, 32'h0000_0000};

    a_if.read = 1'b0; a_if.write = 1'b0; a_if.memory_addr = '0;
    a_if.data_to_write = '0; a_if.access_size = '0; a_if.load_unsigned = 1'b0;
    b_if.read = 1'b0; b_if.write = 1'b0; b_if.memory_addr = '0;
    b_if.data_to_write = '0; b_if.access_size = 2'd2; b_if.load_unsigned = 1'b0;
    mdl_rd = 32'h0;

    repeat (3) @(negedge clk);
    check("rst_busy", 32'(a_if.mem_busy), 32'd0);
    check("rst_done", 32'(a_if.mem_done), 32'd0);
    check("rst_mis", 32'(a_if.misaligned_error), 32'd0);
    check("rst_rdata", a_if.read_data_from_memory_controller, 32'h0);
    check("rst_b_busy", 32'(b_if.mem_busy), 32'd0);
    rst = 1'b0;

    foreach (tbl[i]) begin
      acc_a(tbl[i].wr, tbl[i].addr, tbl[i].data, tbl[i].sz, tbl[i].uns, rd, mis);
      check($sformatf("tbl%0d_mis", i), 32'(mis), 32'(tbl[i].mis));
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
    end

    // read and write together in IDLE must be ignored
    @(negedge clk);
    a_if.read = 1'b1; a_if.write = 1'b1; a_if.memory_addr = 32'h100; a_if.access_size = 2'd2;
    @(negedge clk);
    a_if.read = 1'b0; a_if.write = 1'b0;
    check("both_busy", 32'(a_if.mem_busy), 32'd0);
    @(negedge clk);
    check("both_busy2", 32'(a_if.mem_busy), 32'd0);
    check("both_done", 32'(a_if.mem_done), 32'd0);

    // reset during WAIT aborts the store
    acc_a(1'b1, 32'h200, 32'h0102_0304, 2'd2, 1'b0, rd, mis);
    @(negedge clk);
    a_if.write = 1'b1; a_if.memory_addr = 32'h200; a_if.data_to_write = 32'hCAFE_F00D; a_if.access_size = 2'd2;
    @(negedge clk);
    a_if.write = 1'b0;
    check("rstw_busy_pre", 32'(a_if.mem_busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstw_busy", 32'(a_if.mem_busy), 32'd0);
    check("rstw_done", 32'(a_if.mem_done), 32'd0);
    check("rstw_rdata", a_if.read_data_from_memory_controller, 32'h0);
    mdl_rd = 32'h0;

    // reset during DONE also blocks the commit
    @(negedge clk);
    a_if.write = 1'b1; a_if.memory_addr = 32'h200; a_if.data_to_write = 32'h1234_5678;
    @(negedge clk);
    a_if.write = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rstd_in_done", 32'(a_if.mem_done), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstd_done", 32'(a_if.mem_done), 32'd0);
    acc_a(1'b0, 32'h200, 32'h0, 2'd2, 1'b0, rd, mis);
    check("rst_store_aborted", rd, 32'h0102_0304);

    // random traffic in a small region, with upper address bits exercising the wrap
    for (int w = 0; w < 16; w++) begin
      acc_a(1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, rd, mis);
    end
    for (int k = 0; k < 250; k++) begin
      wr  = bit'($urandom_range(0, 1));
      ad  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      d   = $urandom;
      sz  = 2'($urandom_range(0, 3));
      uns = bit'($urandom_range(0, 1));
      acc_a(wr, ad, d, sz, uns, rd, mis);
      check($sformatf("rnd%0d_mis", k), 32'(mis), 32'(model_mis(sz, ad)));
      check($sformatf("rnd%0d_rdata", k), rd, mdl_rd);
    end

    // zero-wait instance: one-cycle latency, requests during DONE ignored
    b_store(32'h40, 32'h89AB_CDEF);
    b_store(32'h44, 32'h00C0_FFEE);
    @(negedge clk);
    b_if.read = 1'b1; b_if.memory_addr = 32'h40; b_if.access_size = 2'd2;
    @(negedge clk);
    check("b_done_lat", 32'(b_if.mem_done), 32'd1);
    check("b_busy_done", 32'(b_if.mem_busy), 32'd1);
    b_if.memory_addr = 32'h44;
    @(negedge clk);
    b_if.read = 1'b0;
    check("b_ignored_done", 32'(b_if.mem_done), 32'd0);
    check("b_ignored_busy", 32'(b_if.mem_busy), 32'd0);
    check("b_rdata0", b_if.read_data_from_memory_controller, 32'h89AB_CDEF);
    @(negedge clk);
    check("b_gap_busy", 32'(b_if.mem_busy), 32'd0);
    b_if.read = 1'b1; b_if.memory_addr = 32'h44;
    @(negedge clk);
    b_if.read = 1'b0;
    check("b_done_lat2", 32'(b_if.mem_done), 32'd1);
    @(negedge clk);
    check("b_done_clear", 32'(b_if.mem_done), 32'd0);
    check("b_rdata1", b_if.read_data_from_memory_controller, 32'h00C0_FFEE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
